// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, instruction-SRAM req/gnt/rvalid
// handshake, a single-entry IF/ID buffer, and branch redirect with one delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  // One-hot encoding: each output flag is a single state flop.
  typedef enum logic [2:0] {
    S_REQ  = 3'b001,
    S_WAIT = 3'b010,
    S_FULL = 3'b100
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] if_inst_reg;
  logic [31:0] if_pc_reg;
  logic        redir_pend_reg;
  logic [31:0] redir_tgt_reg;

  logic        handoff;
  logic [31:0] next_pc;

  // Decode takes the buffered instruction this cycle.
  assign handoff = (state_reg == S_FULL) && id_allowin;

  // Outputs come straight from flops; no combinational path from inputs.
  assign inst_req  = state_reg[0];
  assign inst_addr = pc_reg;
  assign if_valid  = state_reg[2];
  assign if_inst   = if_inst_reg;
  assign if_pc     = if_pc_reg;

  // Next fetch address: a same-cycle branch wins over a remembered redirect,
  // otherwise sequential (wraps naturally at 32 bits).
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_valid) begin
      next_pc = br_target;
    end else if (redir_pend_reg) begin
      next_pc = redir_tgt_reg;
    end
  end

  // Fetch FSM, PC, IF/ID buffer and redirect capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_REQ;
      pc_reg         <= RESET_PC;
      if_inst_reg    <= 32'd0;
      if_pc_reg      <= 32'd0;
      redir_pend_reg <= 1'b0;
      redir_tgt_reg  <= 32'd0;
    end else begin
      // A redirect that misses the handoff is held until the delay slot
      // is handed off; a later one simply overwrites the target.
      if (handoff) begin
        redir_pend_reg <= 1'b0;
      end else if (br_valid) begin
        redir_pend_reg <= 1'b1;
        redir_tgt_reg  <= br_target;
      end

      case (state_reg)
        S_REQ: begin
          if (inst_gnt) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_rvalid) begin
            if_inst_reg <= inst_rdata;
            if_pc_reg   <= pc_reg;
            state_reg   <= S_FULL;
          end
        end
        S_FULL: begin
          if (id_allowin) begin
            pc_reg    <= next_pc;
            state_reg <= S_REQ;
          end
        end
        default: begin
          state_reg <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized run
// against a PC-sequence model with a randomly timed SRAM and decode stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt = 1'b0;
  logic        inst_rvalid = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        id_allowin = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(32'hbfc00000)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .id_allowin(id_allowin), .br_valid(br_valid), .br_target(br_target),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h24080001;
    return {a[15:0], a[31:16]} ^ 32'h8c420000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Service one fetch currently in REQ: grant after gd cycles, data rd cycles after grant.
  task automatic serve(input int gd, input int rd, input logic [31:0] addr, input bit spur);
    for (int i = 0; i < gd; i++) begin
      check("req_hold", inst_req, 1);
      check("addr_hold", inst_addr, addr);
      inst_rvalid = spur;
      inst_rdata  = 32'hbad0bad0;
      tick();
      inst_rvalid = 1'b0;
      check("spur_ignored", if_valid, 0);
    end
    check("req", inst_req, 1);
    check("addr", inst_addr, addr);
    inst_gnt = 1'b1;
    tick();
    inst_gnt = 1'b0;
    for (int i = 1; i < rd; i++) begin
      check("wait_noreq", inst_req, 0);
      check("wait_novalid", if_valid, 0);
      tick();
    end
    inst_rvalid = 1'b1;
    inst_rdata  = mem(addr);
    tick();
    inst_rvalid = 1'b0;
    check("if_valid", if_valid, 1);
    check("if_pc", if_pc, addr);
    check("if_inst", if_inst, mem(addr));
    $display("xfer pc=%h inst=%h", if_pc, if_inst);
  endtask

  task automatic handoff(input bit br, input logic [31:0] tgt);
    id_allowin = 1'b1;
    br_valid   = br;
    br_target  = tgt;
    tick();
    id_allowin = 1'b0;
    br_valid   = 1'b0;
    check("post_handoff_req", inst_req, 1);
  endtask

  // Random-phase model state
  logic [31:0] exp_pc, pend_tgt, arm_tgt, req_addr, out_addr;
  bit          pend, armed, ds_next, was_ds, req_seen, outstanding, hand;
  int          gnt_cnt, rv_cnt, idle, handoffs;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_req", inst_req, 1);
    check("rst_addr", inst_addr, 32'hbfc00000);
    check("rst_valid", if_valid, 0);
    check("rst_inst", if_inst, 0);
    check("rst_pc", if_pc, 0);
    rst = 1'b0;

    // Sequential fetch at minimum latency
    serve(0, 1, 32'hbfc00000, 0);
    handoff(0, 0);
    serve(0, 1, 32'hbfc00004, 0);
    handoff(0, 0);
    serve(0, 1, 32'hbfc00008, 0);

    // Stall in FULL
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", if_valid, 1);
      check("stall_pc", if_pc, 32'hbfc00008);
      check("stall_inst", if_inst, mem(32'hbfc00008));
      check("stall_noreq", inst_req, 0);
    end
    handoff(0, 0);
    serve(0, 1, 32'hbfc0000c, 0);
    handoff(0, 0);

    // Branch at bfc00010, redirect arrives while delay slot is in WAIT
    serve(0, 1, 32'hbfc00010, 0);
    handoff(0, 0);
    check("ds_addr", inst_addr, 32'hbfc00014);
    inst_gnt = 1'b1;
    tick();
    inst_gnt   = 1'b0;
    br_valid   = 1'b1;
    br_target  = 32'hbfc00100;
    tick();
    br_valid = 1'b0;
    check("ds_wait_noreq", inst_req, 0);
    check("ds_wait_novalid", if_valid, 0);
    inst_rvalid = 1'b1;
    inst_rdata  = mem(32'hbfc00014);
    tick();
    inst_rvalid = 1'b0;
    check("ds_pc", if_pc, 32'hbfc00014);
    check("ds_inst", if_inst, mem(32'hbfc00014));
    $display("xfer pc=%h inst=%h", if_pc, if_inst);
    handoff(0, 0);
    serve(0, 1, 32'hbfc00100, 0);
    handoff(0, 0);
    serve(0, 1, 32'hbfc00104, 0);

    // Redirect bypass on delay-slot handoff
    handoff(0, 0);
    serve(0, 1, 32'hbfc00108, 0);
    handoff(1, 32'hbfc00200);
    serve(0, 1, 32'hbfc00200, 0);
    handoff(0, 0);

    // Slow SRAM with spurious rvalid during REQ; sequential after bypass
    serve(3, 4, 32'hbfc00204, 1);
    handoff(0, 0);

    // Reset during WAIT, stale response afterwards
    check("pre_rst_addr", inst_addr, 32'hbfc00208);
    inst_gnt = 1'b1;
    tick();
    inst_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_req", inst_req, 1);
    check("rstw_addr", inst_addr, 32'hbfc00000);
    check("rstw_valid", if_valid, 0);
    check("rstw_pc", if_pc, 0);
    inst_rvalid = 1'b1;
    inst_rdata  = 32'hdeaddead;
    tick();
    inst_rvalid = 1'b0;
    check("stale_valid", if_valid, 0);
    check("stale_inst", if_inst, 0);
    check("stale_addr", inst_addr, 32'hbfc00000);
    serve(0, 1, 32'hbfc00000, 0);

    // Wrap at top of address space
    handoff(0, 0);
    serve(0, 1, 32'hbfc00004, 0);
    handoff(1, 32'hfffffffc);
    serve(0, 1, 32'hfffffffc, 0);
    handoff(0, 0);
    serve(0, 1, 32'h00000000, 0);
    handoff(0, 0);

    // Randomized run
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_pc = 32'hbfc00000;
    pend = 0; armed = 0; ds_next = 0; req_seen = 0; outstanding = 0;
    gnt_cnt = $urandom_range(0, 2);
    rv_cnt = 0; idle = 0; handoffs = 0;
    pend_tgt = 0; arm_tgt = 0; req_addr = 0; out_addr = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      // SRAM side
      inst_gnt    = 1'b0;
      inst_rvalid = 1'b0;
      inst_rdata  = $urandom;
      if (outstanding) begin
        if (rv_cnt == 0) begin
          inst_rvalid = 1'b1;
          inst_rdata  = mem(out_addr);
          outstanding = 0;
        end else begin
          rv_cnt--;
        end
      end else if (inst_req) begin
        if (req_seen) check("rnd_addr_stable", inst_addr, req_addr);
        req_seen = 1;
        req_addr = inst_addr;
        inst_rvalid = ($urandom_range(0, 3) == 0);
        if (gnt_cnt == 0) begin
          inst_gnt = 1'b1;
          check("rnd_addr_align", {30'd0, inst_addr[1:0]}, 0);
          outstanding = 1;
          out_addr = inst_addr;
          rv_cnt = $urandom_range(0, 3);
          gnt_cnt = $urandom_range(0, 2);
          req_seen = 0;
        end else begin
          gnt_cnt--;
        end
      end else begin
        inst_rvalid = ($urandom_range(0, 3) == 0);
      end

      // Decode side
      br_valid  = 1'b0;
      br_target = $urandom;
      hand = if_valid && ($urandom_range(0, 2) != 0);
      id_allowin = hand;
      if (armed && (hand || $urandom_range(0, 2) == 0)) begin
        br_valid  = 1'b1;
        br_target = arm_tgt;
        armed     = 0;
        pend      = 1;
        pend_tgt  = arm_tgt;
      end
      if (hand) begin
        check("rnd_pc", if_pc, exp_pc);
        check("rnd_inst", if_inst, mem(exp_pc));
        $display("xfer pc=%h inst=%h br=%0d", if_pc, if_inst, br_valid);
        was_ds = ds_next;
        ds_next = 0;
        exp_pc = pend ? pend_tgt : exp_pc + 32'd4;
        pend = 0;
        if (!was_ds && $urandom_range(0, 3) == 0) begin
          armed = 1;
          ds_next = 1;
          arm_tgt = $urandom & 32'hfffffffc;
        end
        handoffs++;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 40) begin
        check("rnd_timeout", idle, 0);
        break;
      end
      tick();
    end
    id_allowin  = 1'b0;
    br_valid    = 1'b0;
    inst_gnt    = 1'b0;
    inst_rvalid = 1'b0;
    check("rnd_progress", {31'd0, handoffs >= 100}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
